// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: three-requester arbiter in front of a shared SPI flash/PSRAM memory controller
module spi_mem_arbiter #(
    parameter bit FIXED_PRIO_0   = 1'b1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    input  logic [2:0]  req_we,
    input  logic [2:0]  req_select,
    input  logic [5:0]  req_length,
    input  logic [71:0] req_addr,
    input  logic [95:0] req_wdata,
    output logic [31:0] req_rdata,
    output logic [2:0]  req_ready,
    output logic [2:0]  req_err,
    output logic        mem_valid,
    output logic        mem_we,
    output logic        mem_select,
    output logic [1:0]  mem_length,
    output logic [23:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [2:0]  grant,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [9:0] T_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_select_q, mem_select_d;
    logic [1:0]  mem_length_q, mem_length_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [1:0] a, b, win, gidx;
    logic       in_grant, vg, hit, done, err_hit;

    // status of the current grant; reset suppresses every completion or abort pulse
    always_comb begin
        in_grant = (state_q == GRANT) && !reset;
        vg       = |(req_valid & grant_q);
        hit      = cnt_q == T_LAST;
        done     = in_grant && vg && mem_ready;
        err_hit  = in_grant && vg && !mem_ready && hit;
        gidx     = grant_q[2] ? 2'd2 : grant_q[1] ? 2'd1 : 2'd0;
        a        = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        b        = (a == 2'd2) ? 2'd0 : a + 2'd1;
        win      = (FIXED_PRIO_0 && req_valid[0]) ? 2'd0 :
                   req_valid[a] ? a : req_valid[b] ? b : last_q;
    end

    // completion and abort handshakes toward requesters and the memory controller
    always_comb begin
        mem_valid = in_grant && vg && (!hit || mem_ready);
        req_ready = done ? grant_q : 3'b000;
        req_err   = err_hit ? grant_q : 3'b000;
        req_rdata = done ? mem_rdata : 32'h0;
    end

    assign grant      = grant_q;
    assign busy       = state_q != IDLE;
    assign mem_we     = mem_we_q;
    assign mem_select = mem_select_q;
    assign mem_length = mem_length_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    // next-state logic: latch the winner's request in IDLE, hold it through GRANT, drop it after RELEASE
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        mem_we_d     = mem_we_q;
        mem_select_d = mem_select_q;
        mem_length_d = mem_length_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                state_d      = GRANT;
                grant_d      = 3'b001 << win;
                cnt_d        = 10'd0;
                mem_we_d     = req_we[win];
                mem_select_d = req_select[win];
                mem_length_d = req_length[win*2 +: 2];
                mem_addr_d   = req_addr[win*24 +: 24];
                mem_wdata_d  = req_wdata[win*32 +: 32];
            end
            GRANT: begin
                cnt_d = cnt_q + 10'd1;
                if (!vg || mem_ready || hit) state_d = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
                grant_d = 3'b000;
                last_d  = gidx;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; last_grant restarts at 2 so requester 0 is searched first
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 3'b000;
            last_q       <= 2'd2;
            cnt_q        <= 10'd0;
            mem_we_q     <= 1'b0;
            mem_select_q <= 1'b0;
            mem_length_q <= 2'd0;
            mem_addr_q   <= 24'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_select_q <= mem_select_d;
            mem_length_q <= mem_length_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: directed scoreboard bench for spi_mem_arbiter (fixed-priority and round-robin instances)
module tb_spi_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rv0, rv1, req_we, req_select;
    logic [5:0]  req_length;
    logic [71:0] req_addr;
    logic [95:0] req_wdata;
    logic [31:0] mem_rdata;
    logic        mr0, mr1;

    logic [31:0] rdata0, rdata1, mwd0, mwd1;
    logic [2:0]  rdy0, rdy1, err0, err1, grant0, grant1;
    logic        mv0, mv1, mwe0, mwe1, msel0, msel1, busy0, busy1;
    logic [1:0]  mlen0, mlen1;
    logic [23:0] maddr0, maddr1;

    always #5 clk = ~clk;

    spi_mem_arbiter #(.FIXED_PRIO_0(1'b1), .TIMEOUT_CYCLES(8)) u0 (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_we(req_we), .req_select(req_select),
        .req_length(req_length), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdata(rdata0), .req_ready(rdy0), .req_err(err0),
        .mem_valid(mv0), .mem_we(mwe0), .mem_select(msel0), .mem_length(mlen0),
        .mem_addr(maddr0), .mem_wdata(mwd0), .mem_rdata(mem_rdata), .mem_ready(mr0),
        .grant(grant0), .busy(busy0));

    spi_mem_arbiter #(.FIXED_PRIO_0(1'b0), .TIMEOUT_CYCLES(8)) u1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_we(req_we), .req_select(req_select),
        .req_length(req_length), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdata(rdata1), .req_ready(rdy1), .req_err(err1),
        .mem_valid(mv1), .mem_we(mwe1), .mem_select(msel1), .mem_length(mlen1),
        .mem_addr(maddr1), .mem_wdata(mwd1), .mem_rdata(mem_rdata), .mem_ready(mr1),
        .grant(grant1), .busy(busy1));

    typedef struct packed {
        logic [2:0]  rdy;
        logic [2:0]  err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [2:0] g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] r, input logic [2:0] e, input logic [31:0] d);
        mk = {r, e, d};
    endfunction

    // every ready/err pulse of the fixed-priority instance must match the next queued expectation
    always @(negedge clk) begin
        if (!reset && (rdy0 != 3'b000 || err0 != 3'b000)) begin
            if (sbq.size() == 0) chk("sb_unexpected", {rdy0, err0}, 64'h0);
            else begin
                mon_e = sbq.pop_front();
                chk("sb_ready", rdy0, mon_e.rdy);
                chk("sb_err", err0, mon_e.err);
                chk("sb_rdata", rdata0, mon_e.rdata);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic sel, input logic [1:0] len,
                           input logic [23:0] addr, input logic [31:0] wd);
        req_we[i]             = we;
        req_select[i]         = sel;
        req_length[i*2 +: 2]  = len;
        req_addr[i*24 +: 24]  = addr;
        req_wdata[i*32 +: 32] = wd;
    endtask

    task automatic wait_mv(input bit which, input string tag);
        int k = 0;
        @(negedge clk);
        while (((which ? mv1 : mv0) !== 1'b1) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk({tag, "_wait_expired"}, {63'b0, which ? mv1 : mv0}, 64'h1);
    endtask

    task automatic serve(input bit which, input logic [31:0] rd, output logic [2:0] gg);
        wait_mv(which, "serve");
        gg = which ? grant1 : grant0;
        cyc();
        if (which) mr1 = 1'b1;
        else mr0 = 1'b1;
        mem_rdata = rd;
        if (!which) sbq.push_back(mk(gg, 3'b000, rd));
        @(negedge clk);
        if (which) chk("rr_ready", rdy1, gg);
        cyc();
        mr0 = 1'b0;
        mr1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rv0 = '0; rv1 = '0; req_we = '0; req_select = '0;
        req_length = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0; mr0 = 1'b0; mr1 = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_grant", grant0, 3'b000);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_mv", mv0, 1'b0);
        chk("rst_addr", maddr0, 24'h0);
        chk("rst_len", mlen0, 2'd0);
        chk("rst_rdy_err", {rdy0, err0}, 6'h0);
        chk("rst_grant1", grant1, 3'b000);

        // single read by requester 1
        cyc();
        set_req(1, 1'b0, 1'b1, 2'd3, 24'h012345, 32'h0);
        rv0 = 3'b010;
        mem_rdata = 32'h11111111;
        @(negedge clk);
        chk("t1_idle_mv", mv0, 1'b0);
        cyc();
        @(negedge clk);
        chk("t1_mv", mv0, 1'b1);
        chk("t1_grant", grant0, 3'b010);
        chk("t1_addr", maddr0, 24'h012345);
        chk("t1_sel", msel0, 1'b1);
        chk("t1_len", mlen0, 2'd3);
        chk("t1_we", mwe0, 1'b0);
        chk("t1_busy", busy0, 1'b1);
        chk("t1_rdata_idle", rdata0, 32'h0);
        cyc();
        set_req(1, 1'b1, 1'b0, 2'd0, 24'hFFFFFF, 32'h5555);
        @(negedge clk);
        chk("t1_hold_addr", maddr0, 24'h012345);
        chk("t1_hold_sel", msel0, 1'b1);
        chk("t1_hold_we", mwe0, 1'b0);
        cyc();
        mr0 = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        sbq.push_back(mk(3'b010, 3'b000, 32'hDEADBEEF));
        @(negedge clk);
        chk("t1_rdata", rdata0, 32'hDEADBEEF);
        cyc();
        mr0 = 1'b0;
        rv0 = 3'b000;
        @(negedge clk);
        chk("t1_rel_mv", mv0, 1'b0);
        chk("t1_rel_busy", busy0, 1'b1);
        chk("t1_rel_grant", grant0, 3'b010);
        cyc();
        mr0 = 1'b1;
        @(negedge clk);
        chk("t1_idle_busy", busy0, 1'b0);
        chk("t1_idle_grant", grant0, 3'b000);
        cyc();
        mr0 = 1'b0;

        // fixed priority: requester 0 always wins, then 1/2 alternate
        set_req(0, 1'b1, 1'b0, 2'd1, 24'h000100, 32'hA0A0A0A0);
        set_req(1, 1'b0, 1'b1, 2'd2, 24'h000200, 32'hB1B1B1B1);
        set_req(2, 1'b1, 1'b1, 2'd0, 24'h000300, 32'hC2C2C2C2);
        rv0 = 3'b111;
        for (int i = 0; i < 3; i++) begin
            serve(1'b0, 32'h1000 + i, g);
            chk("prio0_grant", g, 3'b001);
        end
        rv0 = 3'b110;
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, 32'h2000 + i, g);
            chk("prio12_grant", g, (i % 2 == 0) ? 3'b010 : 3'b100);
        end
        rv0 = 3'b000;
        cyc();
        cyc();

        // plain round-robin instance
        rv1 = 3'b111;
        for (int i = 0; i < 5; i++) begin
            serve(1'b1, 32'h3000 + i, g);
            chk("rr_grant", g, (i % 3 == 0) ? 3'b001 : (i % 3 == 1) ? 3'b010 : 3'b100);
        end
        rv1 = 3'b000;
        cyc();
        cyc();

        // requester 2 aborts five cycles into its grant; mem_ready in that cycle is ignored
        set_req(2, 1'b1, 1'b1, 2'd2, 24'hABCDEF, 32'h12345678);
        rv0 = 3'b100;
        wait_mv(1'b0, "ab");
        chk("ab_grant", grant0, 3'b100);
        chk("ab_wdata", mwd0, 32'h12345678);
        repeat (3) cyc();
        @(negedge clk);
        chk("ab_mv_pre", mv0, 1'b1);
        cyc();
        rv0 = 3'b000;
        mr0 = 1'b1;
        @(negedge clk);
        chk("ab_mv", mv0, 1'b0);
        chk("ab_rdy", rdy0, 3'b000);
        chk("ab_err", err0, 3'b000);
        chk("ab_busy", busy0, 1'b1);
        cyc();
        mr0 = 1'b0;
        @(negedge clk);
        chk("ab_rel_busy", busy0, 1'b1);
        chk("ab_rel_mv", mv0, 1'b0);
        cyc();
        @(negedge clk);
        chk("ab_idle_busy", busy0, 1'b0);
        chk("ab_idle_grant", grant0, 3'b000);

        // timeout after eight GRANT cycles without mem_ready
        rv0 = 3'b010;
        wait_mv(1'b0, "to");
        repeat (6) cyc();
        @(negedge clk);
        chk("to_c7_mv", mv0, 1'b1);
        chk("to_c7_err", err0, 3'b000);
        cyc();
        sbq.push_back(mk(3'b000, 3'b010, 32'h0));
        @(negedge clk);
        chk("to_mv", mv0, 1'b0);
        chk("to_err", err0, 3'b010);
        cyc();
        rv0 = 3'b000;
        @(negedge clk);
        chk("to_rel_grant", grant0, 3'b010);
        chk("to_rel_busy", busy0, 1'b1);
        cyc();
        @(negedge clk);
        chk("to_grant_clr", grant0, 3'b000);

        // mem_ready arriving on the timeout cycle completes normally
        rv0 = 3'b010;
        wait_mv(1'b0, "col");
        repeat (7) cyc();
        mr0 = 1'b1;
        mem_rdata = 32'hCAFE0008;
        sbq.push_back(mk(3'b010, 3'b000, 32'hCAFE0008));
        @(negedge clk);
        chk("col_rdy", rdy0, 3'b010);
        chk("col_err", err0, 3'b000);
        cyc();
        mr0 = 1'b0;
        rv0 = 3'b000;
        cyc();

        // reset in the middle of a grant
        set_req(0, 1'b1, 1'b1, 2'd3, 24'h555555, 32'h87654321);
        rv0 = 3'b001;
        wait_mv(1'b0, "rs");
        chk("rs_pre_mv", mv0, 1'b1);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        rv0 = 3'b111;
        @(negedge clk);
        chk("rs_mv", mv0, 1'b0);
        chk("rs_grant", grant0, 3'b000);
        chk("rs_busy", busy0, 1'b0);
        chk("rs_rdy_err", {rdy0, err0}, 6'h0);
        chk("rs_addr", maddr0, 24'h0);
        chk("rs_wdata", mwd0, 32'h0);
        serve(1'b0, 32'h4000, g);
        chk("rs_first_grant0", g, 3'b001);
        rv0 = 3'b000;
        cyc();
        rv1 = 3'b111;
        serve(1'b1, 32'h5000, g);
        chk("rs_first_grant1", g, 3'b001);
        rv1 = 3'b000;
        repeat (3) cyc();

        chk("sb_drain", sbq.size(), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_mem_arbiter.md
SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO_0, default 1: requester 0 always wins arbitration when set; plain 3-way round-robin when clear.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum cycles a grant may wait for mem_ready; legal range 1..1023.
REQ-003 SHALL have port clk, input, 1: system clock; the same clock that drives the memory controller's clk.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 3: per-requester access request; bit i is requester i.
REQ-006 SHALL have port req_we, input, 3: per-requester write enable.
REQ-007 SHALL have port req_select, input, 3: per-requester device select (1 = PSRAM, 0 = flash).
REQ-008 SHALL have port req_length, input, 6: per-requester length code, 2 bits each, {r2,r1,r0}.
REQ-009 SHALL have port req_addr, input, 72: per-requester 24-bit address, {r2,r1,r0}.
REQ-010 SHALL have port req_wdata, input, 96: per-requester 32-bit write data, {r2,r1,r0}.
REQ-011 SHALL have port req_rdata, output, 32: read data, shared by all requesters.
REQ-012 SHALL have port req_ready, output, 3: one-cycle completion pulse to the granted requester.
REQ-013 SHALL have port req_err, output, 3: one-cycle timeout-abort pulse to the granted requester.
REQ-014 SHALL have ports mem_valid/mem_we/mem_select (1 each), mem_length (2), mem_addr (24), mem_wdata (32), all outputs to the memory controller.
REQ-015 SHALL have ports mem_rdata (input, 32) and mem_ready (input, 1) from the memory controller.
REQ-016 SHALL have port grant, output, 3: one-hot current owner; all zero when no grant.
REQ-017 SHALL have port busy, output, 1: high in GRANT and RELEASE states.

Function
REQ-018 SHALL implement FSM with states IDLE, GRANT, RELEASE.
REQ-019 IDLE: when any req_valid bit is high, SHALL register the winner into grant, latch that requester's we/select/length/addr/wdata into the mem_* registers, and enter GRANT on the next cycle.
- Latency: req_valid high in cycle N gives mem_valid high in cycle N+1.
REQ-020 Winner selection:
- FIXED_PRIO_0=1: bit 0 wins if set; otherwise round-robin between 1 and 2.
- FIXED_PRIO_0=0: search order starts at last_grant+1 modulo 3.
- last_grant resets to 2, so requester 0 is searched first.
REQ-021 mem_valid SHALL equal (state==GRANT) AND req_valid[granted], combinationally.
- A requester dropping valid therefore aborts the memory access in the same cycle.
REQ-022 GRANT with mem_ready high and req_valid[granted] high:
- SHALL pulse req_ready[granted] in the same cycle.
- req_rdata SHALL equal mem_rdata combinationally while mem_ready is high; it is 0 otherwise.
- SHALL enter RELEASE on the next cycle.
REQ-023 GRANT with req_valid[granted] low: SHALL enter RELEASE with no req_ready or req_err pulse, and SHALL ignore mem_ready in that cycle.
REQ-024 GRANT timeout counter (10-bit):
- Cleared on entry to GRANT; increments each GRANT cycle.
- When it reaches TIMEOUT_CYCLES without mem_ready: mem_valid SHALL be forced low, req_err[granted] SHALL pulse, and the FSM SHALL enter RELEASE.
REQ-025 mem_ready and timeout in the same cycle: completion SHALL win; req_ready pulses and req_err does not.
REQ-026 RELEASE: SHALL last exactly one cycle with mem_valid low, then return to IDLE.
- grant and last_grant SHALL update on leaving RELEASE.
- Earliest back-to-back re-grant is 2 cycles after completion.
REQ-027 mem_ready outside GRANT SHALL be ignored.
REQ-028 Latched mem_* fields SHALL hold stable for the whole grant regardless of requester input changes.

Reset
REQ-029 On reset SHALL clear the following to 0: state=IDLE, grant, mem_valid, req_ready, req_err, mem_we/select/length/addr/wdata, busy, timeout counter.
REQ-030 On reset SHALL set last_grant=2.
REQ-031 Reset asserted mid-GRANT SHALL drop mem_valid in the following cycle, with no ready or err pulse.

Verification
REQ-032 Single request: r1 requests read, addr=0x012345, select=1, length=3 → mem_valid in the next cycle with those fields; mem_ready with rdata=0xDEADBEEF → req_ready=3'b010 and req_rdata=0xDEADBEEF in the same cycle.
REQ-033 Contention, FIXED_PRIO_0=1: all three requesting continuously → grant order 0,0,0…; with r0 dropped → 1,2,1,2. With FIXED_PRIO_0=0 → 0,1,2,0.
REQ-034 Abort: r2 drops req_valid 5 cycles into a grant → mem_valid low in that same cycle, no req_ready, RELEASE then IDLE.
REQ-035 Timeout: TIMEOUT_CYCLES=8, no mem_ready → req_err pulses on the 8th GRANT cycle, mem_valid low, grant cleared 2 cycles later.
REQ-036 Collision and reset: mem_ready on the timeout cycle → req_ready only. Reset mid-grant → all outputs 0 next cycle, first post-reset grant goes to r0.
